// File: rtl/spi_cmd_packer.sv
`default_nettype none
// ------------------------------------------------------------------------
// spi_cmd_packer: frames SPI bytes into WIDTH-bit command words for the FIFO.
// Optional stats counters via SPI_CMD_PACKER_STATS_EN.      Rev 1.0
// ------------------------------------------------------------------------
module spi_cmd_packer #(
  parameter  int WIDTH  = 72,
  localparam int NBYTES = WIDTH / 8
) (
  input  logic             wr_clk,
  input  logic             wr_rst_n,
  input  logic             byte_valid,
  input  logic [7:0]       byte_data,
  input  logic             frame_end,
  output logic             fifo_wr_en,
  output logic [WIDTH-1:0] fifo_wr_data,
  input  logic             fifo_full,
  input  logic             fifo_almost_full,
  output logic             busy,
  output logic             err_short,
  output logic             err_long,
  output logic             err_drop,
`ifdef SPI_CMD_PACKER_STATS_EN
  output logic [15:0]      cmd_count,
  output logic [15:0]      drop_count,
  output logic [15:0]      err_count,
`endif
  input  logic             err_clr
);

  localparam int              CNT_W    = $clog2(NBYTES + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NBYTES);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_DONE    = 2'd2;
  localparam logic [1:0] S_DISCARD = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] data_q;
  logic             pending_q;
  logic             busy_q;
  logic             err_short_q, err_long_q, err_drop_q;
  logic             commit, short_ev, long_ev, drop_ev;

  // The byte is applied first; frame_end then sees the post-byte state.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    commit   = 1'b0;
    short_ev = 1'b0;
    long_ev  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (byte_valid) begin
          shift_d = WIDTH'(byte_data);
          cnt_d   = CNT_W'(1);
          state_d = S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (byte_valid) begin
          shift_d = (shift_q << 8) | WIDTH'(byte_data);
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        if (byte_valid) begin
          long_ev = 1'b1;
          state_d = S_DISCARD;
        end
      end
      default: ;
    endcase
    if (state_d == S_COLLECT && cnt_d == CNT_FULL) begin
      commit  = 1'b1;
      state_d = S_DONE;
    end
    if (frame_end) begin
      short_ev = (state_d == S_COLLECT);
      state_d  = S_IDLE;
      cnt_d    = '0;
    end
  end

  assign fifo_wr_en = pending_q & ~fifo_full;
  assign drop_ev    = commit & pending_q & ~fifo_wr_en;

  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      pending_q   <= 1'b0;
      busy_q      <= 1'b0;
      err_short_q <= 1'b0;
      err_long_q  <= 1'b0;
      err_drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      // A commit that lands on a push cycle overwrites the outgoing word.
      if (commit && !drop_ev) begin
        data_q    <= shift_d;
        pending_q <= 1'b1;
      end else if (fifo_wr_en) begin
        pending_q <= 1'b0;
      end
      busy_q      <= fifo_almost_full | pending_q | (state_q != S_IDLE);
      err_short_q <= short_ev | (err_short_q & ~err_clr);
      err_long_q  <= long_ev  | (err_long_q  & ~err_clr);
      err_drop_q  <= drop_ev  | (err_drop_q  & ~err_clr);
    end
  end

  assign fifo_wr_data = data_q;
  assign busy         = busy_q;
  assign err_short    = err_short_q;
  assign err_long     = err_long_q;
  assign err_drop     = err_drop_q;

`ifdef SPI_CMD_PACKER_STATS_EN
  logic [15:0] cmd_cnt_q, drop_cnt_q, err_cnt_q;

  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      cmd_cnt_q  <= '0;
      drop_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else if (err_clr) begin
      cmd_cnt_q  <= '0;
      drop_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      if (fifo_wr_en && cmd_cnt_q != 16'hFFFF)
        cmd_cnt_q <= cmd_cnt_q + 16'd1;
      if (drop_ev && drop_cnt_q != 16'hFFFF)
        drop_cnt_q <= drop_cnt_q + 16'd1;
      if ((short_ev || long_ev) && err_cnt_q != 16'hFFFF)
        err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign cmd_count  = cmd_cnt_q;
  assign drop_count = drop_cnt_q;
  assign err_count  = err_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_spi_cmd_packer.sv
`default_nettype none
// ------------------------------------------------------------------------
// tb_spi_cmd_packer: directed and random frames against a frame-level model.
// ------------------------------------------------------------------------
module tb_spi_cmd_packer;
  localparam int WIDTH = 72;
  localparam int NB    = WIDTH / 8;

  logic             wr_clk = 1'b0;
  logic             wr_rst_n = 1'b0;
  logic             byte_valid = 1'b0;
  logic [7:0]       byte_data = 8'h00;
  logic             frame_end = 1'b0;
  logic             fifo_full = 1'b0;
  logic             fifo_almost_full = 1'b0;
  logic             err_clr = 1'b0;
  logic             fifo_wr_en;
  logic [WIDTH-1:0] fifo_wr_data;
  logic             busy, err_short, err_long, err_drop;
`ifdef SPI_CMD_PACKER_STATS_EN
  logic [15:0]      cmd_count, drop_count, err_count;
  logic [15:0]      m_cmd, m_dropc, m_errc;
`endif

  spi_cmd_packer #(.WIDTH(WIDTH)) dut (
    .wr_clk(wr_clk), .wr_rst_n(wr_rst_n),
    .byte_valid(byte_valid), .byte_data(byte_data), .frame_end(frame_end),
    .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
    .fifo_full(fifo_full), .fifo_almost_full(fifo_almost_full),
    .busy(busy), .err_short(err_short), .err_long(err_long), .err_drop(err_drop),
`ifdef SPI_CMD_PACKER_STATS_EN
    .cmd_count(cmd_count), .drop_count(drop_count), .err_count(err_count),
`endif
    .err_clr(err_clr)
  );

  always #5 wr_clk = ~wr_clk;

  int total = 0;
  int bad = 0;
  bit rnd = 1'b0;

  // Frame-level model: bytes seen in the current transaction plus a one-word hold.
  int               m_n;
  logic [WIDTH-1:0] m_word, m_data;
  bit               m_pend, m_busy, m_es, m_el, m_ed;
  logic [WIDTH-1:0] pushq[$];

  task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_n = 0; m_word = '0; m_data = '0;
    m_pend = 0; m_busy = 0; m_es = 0; m_el = 0; m_ed = 0;
`ifdef SPI_CMD_PACKER_STATS_EN
    m_cmd = 0; m_dropc = 0; m_errc = 0;
`endif
  endtask

  task automatic check_all();
    chk("wr_en", WIDTH'(fifo_wr_en), WIDTH'(m_pend & !fifo_full));
    chk("wr_data", fifo_wr_data, m_data);
    chk("busy", WIDTH'(busy), WIDTH'(m_busy));
    chk("err_short", WIDTH'(err_short), WIDTH'(m_es));
    chk("err_long", WIDTH'(err_long), WIDTH'(m_el));
    chk("err_drop", WIDTH'(err_drop), WIDTH'(m_ed));
`ifdef SPI_CMD_PACKER_STATS_EN
    chk("cmd_count", WIDTH'(cmd_count), WIDTH'(m_cmd));
    chk("drop_count", WIDTH'(drop_count), WIDTH'(m_dropc));
    chk("err_count", WIDTH'(err_count), WIDTH'(m_errc));
`endif
  endtask

  task automatic step();
    bit push, commit, sh, lg, drop;
    int n_old;
    if (rnd) begin
      fifo_full        = ($urandom_range(0, 3) == 0);
      fifo_almost_full = ($urandom_range(0, 4) == 0);
      err_clr          = ($urandom_range(0, 31) == 0);
    end
    @(posedge wr_clk);
    n_old  = m_n;
    push   = m_pend && !fifo_full;
    commit = 0; sh = 0; lg = 0;
    if (byte_valid) begin
      m_n++;
      if (m_n <= NB) m_word = (m_word << 8) | WIDTH'(byte_data);
      if (m_n == NB) commit = 1;
      if (m_n == NB + 1) lg = 1;
    end
    if (frame_end) begin
      if (m_n > 0 && m_n < NB) sh = 1;
      m_n = 0;
    end
    m_busy = fifo_almost_full | m_pend | (n_old != 0);
    drop = commit && m_pend && !push;
    if (push) pushq.push_back(m_data);
    if (commit && !drop) begin
      m_data = m_word;
      m_pend = 1;
    end else if (push) begin
      m_pend = 0;
    end
    m_es = sh   | (m_es & !err_clr);
    m_el = lg   | (m_el & !err_clr);
    m_ed = drop | (m_ed & !err_clr);
`ifdef SPI_CMD_PACKER_STATS_EN
    if (err_clr) begin
      m_cmd = 0; m_dropc = 0; m_errc = 0;
    end else begin
      if (push && m_cmd != 16'hFFFF) m_cmd++;
      if (drop && m_dropc != 16'hFFFF) m_dropc++;
      if ((sh || lg) && m_errc != 16'hFFFF) m_errc++;
    end
`endif
    #1;
    check_all();
  endtask

  task automatic send(input logic [7:0] b, input bit fe);
    byte_valid = 1; byte_data = b; frame_end = fe;
    step();
    byte_valid = 0; frame_end = 0;
  endtask

  task automatic fend();
    frame_end = 1;
    step();
    frame_end = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic frame(input logic [7:0] base, input int len, input bit fe_on_last);
    for (int i = 0; i < len; i++) send(base + 8'(i), fe_on_last && (i == len - 1));
    if (!fe_on_last || len == 0) fend();
  endtask

  int               npush;
  logic [WIDTH-1:0] w1;

  initial begin
    model_reset();
    #12;
    wr_rst_n = 1;
    #1;
    check_all();

    // Clean frame: 0x81 then 0x11..0x88.
    send(8'h81, 0);
    for (int i = 1; i <= 8; i++) send(8'(i * 8'h11), 0);
    chk("t1_push_next_cycle", WIDTH'(fifo_wr_en), WIDTH'(1'b1));
    chk("t1_data", fifo_wr_data, 72'h81_1122_3344_5566_7788);
    fend();
    idle(2);
    chk("t1_npush", WIDTH'(pushq.size()), WIDTH'(1));
    chk("t1_word", pushq[0], 72'h81_1122_3344_5566_7788);

    // Short frame, then a clean one.
    frame(8'h40, 4, 0);
    idle(1);
    chk("t2_err_short", WIDTH'(err_short), WIDTH'(1'b1));
    chk("t2_no_push", WIDTH'(pushq.size()), WIDTH'(1));
    frame(8'h50, NB, 0);
    idle(2);
    chk("t2_word", pushq[pushq.size() - 1], 72'h50_5152_5354_5556_5758);

    // Long frame: only first NB bytes emerge.
    err_clr = 1; step(); err_clr = 0;
    npush = pushq.size();
    frame(8'h60, 11, 0);
    idle(2);
    chk("t3_err_long", WIDTH'(err_long), WIDTH'(1'b1));
    chk("t3_npush", WIDTH'(pushq.size() - npush), WIDTH'(1));
    chk("t3_word", pushq[pushq.size() - 1], 72'h60_6162_6364_6566_6768);

    // FIFO full across two frames: first held, second dropped.
    npush = pushq.size();
    fifo_full = 1;
    frame(8'hA0, NB, 1);
    frame(8'hB0, NB, 1);
    idle(2);
    chk("t4_err_drop", WIDTH'(err_drop), WIDTH'(1'b1));
    chk("t4_held", fifo_wr_data, 72'hA0_A1A2_A3A4_A5A6_A7A8);
    chk("t4_no_push", WIDTH'(pushq.size() - npush), WIDTH'(0));
    fifo_full = 0;
    idle(4);
    chk("t4_one_push", WIDTH'(pushq.size() - npush), WIDTH'(1));
    chk("t4_word", pushq[pushq.size() - 1], 72'hA0_A1A2_A3A4_A5A6_A7A8);

    // Last byte coincident with frame_end.
    err_clr = 1; step(); err_clr = 0;
    frame(8'hC0, NB, 1);
    chk("t5_push", WIDTH'(fifo_wr_en), WIDTH'(1'b1));
    idle(2);
    chk("t5_idle", WIDTH'(busy), WIDTH'(1'b0));
    chk("t5_no_err", WIDTH'({err_short, err_long, err_drop}), WIDTH'(3'b000));

    // Asynchronous reset mid-frame.
    fifo_almost_full = 1;
    for (int i = 0; i < 5; i++) send(8'hD0 + 8'(i), 0);
    #2;
    wr_rst_n = 0;
    #1;
    chk("t6_rst_wr_en", WIDTH'(fifo_wr_en), WIDTH'(1'b0));
    chk("t6_rst_data", fifo_wr_data, '0);
    chk("t6_rst_busy", WIDTH'(busy), WIDTH'(1'b0));
    chk("t6_rst_errs", WIDTH'({err_short, err_long, err_drop}), WIDTH'(3'b000));
    model_reset();
    fifo_almost_full = 0;
    @(posedge wr_clk);
    #1;
    wr_rst_n = 1;
    npush = pushq.size();
    frame(8'hE0, NB, 0);
    idle(2);
    chk("t6_npush", WIDTH'(pushq.size() - npush), WIDTH'(1));
    chk("t6_word", pushq[pushq.size() - 1], 72'hE0_E1E2_E3E4_E5E6_E7E8);

    // Random frames against the model.
    rnd = 1;
    for (int f = 0; f < 250; f++) begin
      int len;
      bit fe_last;
      len     = $urandom_range(0, 12);
      fe_last = $urandom_range(0, 1);
      for (int i = 0; i < len; i++) begin
        send(8'($urandom), fe_last && (i == len - 1));
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      end
      if (!fe_last || len == 0) fend();
      idle($urandom_range(0, 3));
    end
    rnd = 0;
    fifo_full = 0; fifo_almost_full = 0; err_clr = 0;
    idle(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    bad++;
    $display("FAIL timeout observed=running expected=finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end
endmodule
`default_nettype wire

// File: doc/spi_cmd_packer.md
Name: spi_cmd_packer

Overview:
Write-domain stage that sits directly upstream of the GPU command async FIFO. It takes the byte stream delivered by the SPI slave front-end, already synchronised into wr_clk. It frames each SPI transaction into one WIDTH-bit command word and pushes that word into the FIFO write port. Frame errors are detected and dropped, and a registered busy flag is raised so the host can throttle.

Parameters:
- WIDTH, 72, command word width in bits; must be a multiple of 8.
- NBYTES, WIDTH/8, bytes per command frame; derived, do not override.

Ports:
- wr_clk  input  1  write-domain clock.
- wr_rst_n  input  1  reset, asynchronous, active-low; clock wr_clk.
- byte_valid  input  1  one-cycle strobe: byte_data holds a received SPI byte.
- byte_data  input  8  received byte, MSB-first order on the wire.
- frame_end  input  1  one-cycle strobe: chip-select deasserted (end of transaction).
- fifo_wr_en  output  1  push strobe to FIFO write port.
- fifo_wr_data  output  WIDTH  command word to FIFO.
- fifo_full  input  1  FIFO full flag.
- fifo_almost_full  input  1  FIFO DEPTH-2 threshold flag.
- busy  output  1  registered host backpressure flag.
- err_short  output  1  sticky: a frame ended with 1..NBYTES-1 bytes.
- err_long  output  1  sticky: a frame carried more than NBYTES bytes.
- err_drop  output  1  sticky: a complete command was lost because the hold register was occupied.
- err_clr  input  1  synchronous clear of all sticky error flags.

Behaviour:
- Reset values: fifo_wr_en=0, fifo_wr_data=0, busy=0, err_*=0; state=IDLE; byte count=0; pending=0.
- Assembly:
  - Shift register is shifted left by 8 on each accepted byte, so the first byte lands in bits [WIDTH-1:WIDTH-8].
  - Byte counter width is clog2(NBYTES+1).
- State machine:
  - IDLE: on byte_valid, load byte, count=1, go to COLLECT. frame_end in IDLE is ignored (empty frame, no error).
  - COLLECT: each byte_valid shifts and increments the count. On the byte that makes count==NBYTES, commit the word to the hold register and go to DONE. frame_end with count<NBYTES sets err_short, drops the partial word and goes to IDLE.
  - DONE: frame_end goes to IDLE. A byte_valid sets err_long and goes to DISCARD.
  - DISCARD: ignore all bytes; frame_end goes to IDLE. The already-committed word is kept, not retracted.
- Simultaneous byte_valid and frame_end in the same cycle: the byte is processed first, then frame_end is evaluated against the updated count. For example, the NBYTES-th byte together with frame_end commits the word and returns to IDLE.
- Hold register and FIFO push:
  - Commit sets pending=1 and loads fifo_wr_data.
  - fifo_wr_en = pending & !fifo_full (combinational from registers plus fifo_full).
  - pending clears on the cycle fifo_wr_en=1.
- Latency: last byte accepted at edge N; fifo_wr_en is high in cycle N+1 when the FIFO is not full.
- Commit while pending=1 and no push in that cycle: the new word is dropped, err_drop set, hold contents unchanged. Commit in the same cycle as a push: the new word replaces the old one and pending stays 1.
- fifo_wr_data remains stable while pending=1.
- busy is registered: busy <= fifo_almost_full | pending | (state!=IDLE). It is one cycle behind its inputs.
- Sticky errors: a set event in the same cycle as err_clr wins (the flag ends set).
- Reset mid-frame: partial word and pending word are discarded; FIFO contents are outside this block's control.

Optional Feature:
- Macro SPI_CMD_PACKER_STATS_EN.
- When defined, add output ports cmd_count[15:0], drop_count[15:0], err_count[15:0]:
  - cmd_count increments on each fifo_wr_en.
  - drop_count increments on each err_drop event.
  - err_count increments on each err_short or err_long event.
  - All counters saturate at 16'hFFFF, clear on err_clr and reset to 0.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- 9 bytes 0x81,0x11..0x88 then frame_end, FIFO empty -> one fifo_wr_en pulse one cycle after the 9th byte, data=72'h81_1122334455667788 (0x81 followed by bytes 0x11,0x22,…,0x88); no err flags set.
- 4 bytes then frame_end -> no push, err_short=1; next clean 9-byte frame pushes correctly.
- 11 bytes in one frame -> first 9 bytes pushed once, err_long=1, bytes 10-11 never appear in FIFO.
- fifo_full held high for 20 cycles across two complete frames -> first word held stable, second dropped, err_drop=1; after fifo_full falls, exactly one push of the first word.
- NBYTES-th byte and frame_end in the same cycle -> push next cycle, state IDLE, no error.
- wr_rst_n asserted after 5 bytes -> all outputs 0 immediately (asynchronous); a following 9-byte frame pushes correctly.
